// File: rtl/mic1_mem_pkg.sv
// mic1_mem_pkg
// Shared definitions for the main_memory port-A arbiter:
//   - default word width, address width and implemented depth
//   - FSM state encoding (IDLE -> ACCESS -> RESP)
//   - grant identity used for round-robin bookkeeping
package mic1_mem_pkg;

  localparam int DATA_W_DEF    = 9;
  localparam int ADDR_W_DEF    = 9;
  localparam int MEM_DEPTH_DEF = 512;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } gnt_e;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2
// Two-way round-robin grant. Purely combinational; the caller owns the
// last-grant register and only updates it when a grant is actually taken.
// Ports:
//   req_f / req_d   : fetch / data requests
//   last_gnt        : requester granted most recently
//   gnt_f / gnt_d   : one-hot (or zero) grant; never asserted without request
module rr_arb2
  import mic1_mem_pkg::*;
(
  input  logic req_f,
  input  logic req_d,
  input  gnt_e last_gnt,
  output logic gnt_f,
  output logic gnt_d
);

  // Grant selection: a lone requester wins, a tie goes to whoever did not win last.
  always_comb begin
    gnt_f = 1'b0;
    gnt_d = 1'b0;
    if (req_f && req_d) begin
      if (last_gnt == GNT_DATA) begin
        gnt_f = 1'b1;
      end else begin
        gnt_d = 1'b1;
      end
    end else if (req_f) begin
      gnt_f = 1'b1;
    end else if (req_d) begin
      gnt_d = 1'b1;
    end else begin
      gnt_f = 1'b0;
      gnt_d = 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates a fetch (read-only) requester and a data (read/write) requester
// onto port A of main_memory. Every transaction is IDLE -> ACCESS -> RESP.
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   f_req_*/f_rsp_*                  : fetch request / response
//   d_req_*/d_rsp_*                  : data request / response (writes acked too)
//   mem_ren_A, mem_wen_A, mem_addr_A,
//   mem_wdata_A, mem_rdata_A         : main_memory port A (sync-read memory)
//   busy                             : high whenever not in IDLE
module mem_arbiter
  import mic1_mem_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req_valid,
  input  logic [ADDR_W-1:0] f_req_addr,
  output logic              f_req_ready,
  output logic              f_rsp_valid,
  output logic [DATA_W-1:0] f_rsp_data,
  output logic              f_rsp_err,
  input  logic              d_req_valid,
  input  logic              d_req_we,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_req_ready,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_rdata,
  output logic              d_rsp_err,
  output logic              mem_ren_A,
  output logic              mem_wen_A,
  output logic [ADDR_W-1:0] mem_addr_A,
  output logic [DATA_W-1:0] mem_wdata_A,
  input  logic [DATA_W-1:0] mem_rdata_A,
  output logic              busy
);

  // One extra bit so MEM_DEPTH == 2**ADDR_W compares correctly.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);

  state_e            state_q, state_d;
  gnt_e              last_gnt_q, last_gnt_d;
  gnt_e              owner_q, owner_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mem_ren_q, mem_ren_d;
  logic              mem_wen_q, mem_wen_d;
  logic              f_rsp_valid_q, f_rsp_valid_d;
  logic              d_rsp_valid_q, d_rsp_valid_d;
  logic              f_rsp_err_q, f_rsp_err_d;
  logic              d_rsp_err_q, d_rsp_err_d;
  logic              rsp_rd_q, rsp_rd_d;
  logic              busy_q, busy_d;

  logic              arb_gnt_f;
  logic              arb_gnt_d;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_in_range;
  logic              sel_we;

  rr_arb2 u_rr_arb2 (
    .req_f    (f_req_valid),
    .req_d    (d_req_valid),
    .last_gnt (last_gnt_q),
    .gnt_f    (arb_gnt_f),
    .gnt_d    (arb_gnt_d)
  );

  // Ready is combinational so a request is taken in the same IDLE cycle;
  // it is held low during reset even though the state reads IDLE then.
  assign f_req_ready  = rst_n & (state_q == IDLE) & arb_gnt_f;
  assign d_req_ready  = rst_n & (state_q == IDLE) & arb_gnt_d;
  assign sel_addr     = arb_gnt_d ? d_req_addr : f_req_addr;
  assign sel_we       = arb_gnt_d & d_req_we;
  assign sel_in_range = ({1'b0, sel_addr} < DEPTH_L);

  // Next-state, request capture and strobe/response generation.
  always_comb begin
    state_d       = state_q;
    last_gnt_d    = last_gnt_q;
    owner_d       = owner_q;
    we_d          = we_q;
    err_d         = err_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    mem_ren_d     = 1'b0;
    mem_wen_d     = 1'b0;
    f_rsp_valid_d = 1'b0;
    d_rsp_valid_d = 1'b0;
    f_rsp_err_d   = 1'b0;
    d_rsp_err_d   = 1'b0;
    rsp_rd_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (f_req_ready || d_req_ready) begin
          state_d    = ACCESS;
          owner_d    = arb_gnt_d ? GNT_DATA : GNT_FETCH;
          last_gnt_d = arb_gnt_d ? GNT_DATA : GNT_FETCH;
          we_d       = sel_we;
          addr_d     = sel_addr;
          wdata_d    = arb_gnt_d ? d_req_wdata : {DATA_W{1'b0}};
          err_d      = ~sel_in_range;
          // Strobes are registered here so they are high exactly in ACCESS.
          mem_ren_d  = sel_in_range & ~sel_we;
          mem_wen_d  = sel_in_range & sel_we;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (owner_q == GNT_DATA) begin
          d_rsp_valid_d = 1'b1;
          d_rsp_err_d   = err_q;
        end else begin
          f_rsp_valid_d = 1'b1;
          f_rsp_err_d   = err_q;
        end
        rsp_rd_d = ~we_q & ~err_q;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_gnt_q    <= GNT_FETCH;
      owner_q       <= GNT_FETCH;
      we_q          <= 1'b0;
      err_q         <= 1'b0;
      addr_q        <= {ADDR_W{1'b0}};
      wdata_q       <= {DATA_W{1'b0}};
      mem_ren_q     <= 1'b0;
      mem_wen_q     <= 1'b0;
      f_rsp_valid_q <= 1'b0;
      d_rsp_valid_q <= 1'b0;
      f_rsp_err_q   <= 1'b0;
      d_rsp_err_q   <= 1'b0;
      rsp_rd_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_gnt_q    <= last_gnt_d;
      owner_q       <= owner_d;
      we_q          <= we_d;
      err_q         <= err_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      mem_ren_q     <= mem_ren_d;
      mem_wen_q     <= mem_wen_d;
      f_rsp_valid_q <= f_rsp_valid_d;
      d_rsp_valid_q <= d_rsp_valid_d;
      f_rsp_err_q   <= f_rsp_err_d;
      d_rsp_err_q   <= d_rsp_err_d;
      rsp_rd_q      <= rsp_rd_d;
      busy_q        <= busy_d;
    end
  end

  assign mem_ren_A   = mem_ren_q;
  assign mem_wen_A   = mem_wen_q;
  assign mem_addr_A  = addr_q;
  assign mem_wdata_A = wdata_q;
  assign f_rsp_valid = f_rsp_valid_q;
  assign d_rsp_valid = d_rsp_valid_q;
  assign f_rsp_err   = f_rsp_err_q;
  assign d_rsp_err   = d_rsp_err_q;
  assign busy        = busy_q;
  // The memory's read data arrives in RESP (one cycle after the read strobe),
  // so it is forwarded directly, gated by the registered response qualifiers.
  assign f_rsp_data  = (f_rsp_valid_q && rsp_rd_q) ? mem_rdata_A : {DATA_W{1'b0}};
  assign d_rsp_rdata = (d_rsp_valid_q && rsp_rd_q) ? mem_rdata_A : {DATA_W{1'b0}};

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed scenarios against a transaction-level model of the arbiter plus a
// synchronous-read memory standing in for main_memory port A.
module tb_mem_arbiter;

  localparam int DW    = 9;
  localparam int AW    = 9;
  localparam int DEPTH = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          f_req_valid, f_req_ready, f_rsp_valid, f_rsp_err;
  logic [AW-1:0] f_req_addr;
  logic [DW-1:0] f_rsp_data;
  logic          d_req_valid, d_req_we, d_req_ready, d_rsp_valid, d_rsp_err;
  logic [AW-1:0] d_req_addr;
  logic [DW-1:0] d_req_wdata, d_rsp_rdata;
  logic          mem_ren_A, mem_wen_A, busy;
  logic [AW-1:0] mem_addr_A;
  logic [DW-1:0] mem_wdata_A, mem_rdata_A;

  mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req_valid(f_req_valid), .f_req_addr(f_req_addr), .f_req_ready(f_req_ready),
    .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data), .f_rsp_err(f_rsp_err),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready), .d_rsp_valid(d_rsp_valid),
    .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
    .mem_ren_A(mem_ren_A), .mem_wen_A(mem_wen_A), .mem_addr_A(mem_addr_A),
    .mem_wdata_A(mem_wdata_A), .mem_rdata_A(mem_rdata_A), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [DW-1:0] phys [512];
  logic [DW-1:0] refm [512];

  // model: one transaction in its access cycle, one in its response cycle
  logic          acc_v, acc_we, acc_inr, acc_d, rsp_v, rsp_d, rsp_err, last_d;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata, acc_rdata, rsp_data;

  int            ffire[$], dfire[$], ren_c[$], wen_c[$], frsp_c[$], drsp_c[$];
  logic [DW-1:0] frsp_dat[$], drsp_dat[$];
  logic          frsp_e[$], drsp_e[$];

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } dreq_t;
  logic [AW-1:0] fq[$];
  dreq_t         dq[$];

  logic          f_fired, d_fired, pend_ren, pend_wen;
  logic [AW-1:0] pend_addr;
  logic [DW-1:0] pend_wdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_cycle();
    logic idle, egf, egd;
    cyc++;
    f_fired = f_req_valid && f_req_ready;
    d_fired = d_req_valid && d_req_ready;
    if (!rst_n) begin
      chk("rst_f_ready", f_req_ready, 0);
      chk("rst_d_ready", d_req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ren", mem_ren_A, 0);
      chk("rst_wen", mem_wen_A, 0);
      chk("rst_addr", mem_addr_A, 0);
      chk("rst_wdata", mem_wdata_A, 0);
      chk("rst_f_rsp", {f_rsp_valid, f_rsp_err, f_rsp_data}, 0);
      chk("rst_d_rsp", {d_rsp_valid, d_rsp_err, d_rsp_rdata}, 0);
      acc_v = 1'b0; rsp_v = 1'b0; last_d = 1'b0;
    end else begin
      idle = !acc_v && !rsp_v;
      egf  = idle && f_req_valid && (!d_req_valid || last_d);
      egd  = idle && d_req_valid && (!f_req_valid || !last_d);
      chk("f_ready", f_req_ready, egf);
      chk("d_ready", d_req_ready, egd);
      chk("busy", busy, !idle);
      chk("mem_ren", mem_ren_A, acc_v && !acc_we && acc_inr);
      chk("mem_wen", mem_wen_A, acc_v && acc_we && acc_inr);
      if (acc_v && acc_inr) begin
        chk("mem_addr", mem_addr_A, acc_addr);
        if (acc_we) chk("mem_wdata", mem_wdata_A, acc_wdata);
      end
      chk("f_rsp_valid", f_rsp_valid, rsp_v && !rsp_d);
      chk("d_rsp_valid", d_rsp_valid, rsp_v && rsp_d);
      if (rsp_v && rsp_d) begin
        chk("d_rsp_data", d_rsp_rdata, rsp_data);
        chk("d_rsp_err", d_rsp_err, rsp_err);
      end else if (rsp_v) begin
        chk("f_rsp_data", f_rsp_data, rsp_data);
        chk("f_rsp_err", f_rsp_err, rsp_err);
      end
      rsp_v = acc_v; rsp_d = acc_d; rsp_err = !acc_inr; rsp_data = acc_rdata;
      acc_v = egf || egd;
      if (acc_v) begin
        acc_d     = egd;
        last_d    = egd;
        acc_we    = egd && d_req_we;
        acc_addr  = egd ? d_req_addr : f_req_addr;
        acc_wdata = d_req_wdata;
        acc_inr   = (acc_addr < DEPTH);
        acc_rdata = (!acc_we && acc_inr) ? refm[acc_addr] : '0;
        if (acc_we && acc_inr) refm[acc_addr] = acc_wdata;
      end
    end
    if (f_fired) ffire.push_back(cyc);
    if (d_fired) dfire.push_back(cyc);
    if (mem_ren_A) ren_c.push_back(cyc);
    if (mem_wen_A) wen_c.push_back(cyc);
    if (f_rsp_valid) begin frsp_c.push_back(cyc); frsp_dat.push_back(f_rsp_data); frsp_e.push_back(f_rsp_err); end
    if (d_rsp_valid) begin drsp_c.push_back(cyc); drsp_dat.push_back(d_rsp_rdata); drsp_e.push_back(d_rsp_err); end
  endtask

  // Compare at the falling edge, then let the memory respond after the rising edge.
  task automatic step();
    @(negedge clk);
    model_cycle();
    pend_ren = mem_ren_A; pend_wen = mem_wen_A; pend_addr = mem_addr_A; pend_wdata = mem_wdata_A;
    @(posedge clk);
    #1;
    if (pend_wen) phys[pend_addr] = pend_wdata;
    if (pend_ren) mem_rdata_A = phys[pend_addr];
  endtask

  task automatic run(input int maxc);
    int n;
    n = 0;
    while ((fq.size() > 0 || dq.size() > 0 || acc_v || rsp_v) && n < maxc) begin
      f_req_valid = (fq.size() > 0);
      if (f_req_valid) f_req_addr = fq[0];
      d_req_valid = (dq.size() > 0);
      if (d_req_valid) begin d_req_we = dq[0].we; d_req_addr = dq[0].addr; d_req_wdata = dq[0].wdata; end
      step();
      n++;
      if (f_fired) void'(fq.pop_front());
      if (d_fired) void'(dq.pop_front());
    end
    f_req_valid = 1'b0;
    d_req_valid = 1'b0;
    chk("run_incomplete", fq.size() + dq.size() + acc_v + rsp_v, 0);
  endtask

  task automatic clear_log();
    ffire.delete(); dfire.delete(); ren_c.delete(); wen_c.delete();
    frsp_c.delete(); drsp_c.delete(); frsp_dat.delete(); drsp_dat.delete();
    frsp_e.delete(); drsp_e.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    f_req_valid = 1'b0; f_req_addr = '0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = '0; d_req_wdata = '0;
    mem_rdata_A = '0;
    acc_v = 1'b0; acc_we = 1'b0; acc_inr = 1'b0; acc_d = 1'b0; acc_addr = '0;
    acc_wdata = '0; acc_rdata = '0;
    rsp_v = 1'b0; rsp_d = 1'b0; rsp_err = 1'b0; rsp_data = '0; last_d = 1'b0;
    for (int i = 0; i < 512; i++) begin
      phys[i] = DW'(i * 3 + 1);
      refm[i] = phys[i];
    end
    phys[7] = 9'h0CC;
    refm[7] = 9'h0CC;
    do_reset();

    // data write 5 <- 0x0AA, then data read 5
    clear_log();
    dq.push_back('{1'b1, 9'd5, 9'h0AA});
    dq.push_back('{1'b0, 9'd5, 9'h000});
    run(40);
    chk("s1_counts", {dfire.size(), wen_c.size(), drsp_c.size(), frsp_c.size()}, {32'd2, 32'd1, 32'd2, 32'd0});
    if (dfire.size() == 2 && wen_c.size() == 1 && drsp_c.size() == 2) begin
      chk("s1_wen_cycle1", wen_c[0], dfire[0] + 1);
      chk("s1_back_to_back", dfire[1], dfire[0] + 3);
      chk("s1_rsp_cycle2", drsp_c[1], dfire[1] + 2);
      chk("s1_rdata", drsp_dat[1], 9'h0AA);
      chk("s1_err", drsp_e[1], 1'b0);
    end

    // fetch read 7 (preloaded 0x0CC)
    clear_log();
    fq.push_back(9'd7);
    run(40);
    chk("s2_counts", {ffire.size(), ren_c.size(), frsp_c.size(), drsp_c.size()}, {32'd1, 32'd1, 32'd1, 32'd0});
    if (ffire.size() == 1 && ren_c.size() == 1 && frsp_c.size() == 1) begin
      chk("s2_ren_cycle1", ren_c[0], ffire[0] + 1);
      chk("s2_rsp_cycle2", frsp_c[0], ffire[0] + 2);
      chk("s2_data", frsp_dat[0], 9'h0CC);
    end

    // both requesters valid continuously after reset: d, f, d, f ...
    do_reset();
    clear_log();
    dq.push_back('{1'b0, 9'd1, 9'h000});
    dq.push_back('{1'b1, 9'd2, 9'h111});
    dq.push_back('{1'b0, 9'd2, 9'h000});
    dq.push_back('{1'b0, 9'd3, 9'h000});
    fq.push_back(9'd4); fq.push_back(9'd5); fq.push_back(9'd6); fq.push_back(9'd8);
    run(60);
    chk("s3_counts", {ffire.size(), dfire.size(), drsp_c.size()}, {32'd4, 32'd4, 32'd4});
    if (ffire.size() == 4 && dfire.size() == 4 && drsp_c.size() == 4) begin
      chk("s3_f0_after_d0", ffire[0], dfire[0] + 3);
      chk("s3_d1_after_f0", dfire[1], ffire[0] + 3);
      chk("s3_f3_after_d3", ffire[3], dfire[3] + 3);
      chk("s3_raw_data", drsp_dat[2], 9'h111);
    end

    // out-of-range and boundary addresses with DEPTH = 10
    clear_log();
    dq.push_back('{1'b0, 9'd12, 9'h000});
    dq.push_back('{1'b1, 9'd11, 9'h155});
    dq.push_back('{1'b0, 9'd9, 9'h000});
    fq.push_back(9'd10);
    run(60);
    chk("s4_counts", {ren_c.size(), wen_c.size(), drsp_c.size(), frsp_c.size()}, {32'd1, 32'd0, 32'd3, 32'd1});
    if (drsp_c.size() == 3 && frsp_c.size() == 1) begin
      chk("s4_oor_read", {drsp_e[0], drsp_dat[0]}, {1'b1, 9'h000});
      chk("s4_oor_write", drsp_e[1], 1'b1);
      chk("s4_last_word", {drsp_e[2], drsp_dat[2]}, {1'b0, 9'h01C});
      chk("s4_f_oor", {frsp_e[0], frsp_dat[0]}, {1'b1, 9'h000});
    end

    // reset during ACCESS of a data read
    clear_log();
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 9'd7;
    step();
    d_req_valid = 1'b0;
    chk("s5_accepted", d_fired, 1'b1);
    chk("s5_access_ren", mem_ren_A, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("s5_rst_now", {mem_ren_A, busy, mem_addr_A, d_rsp_valid}, 0);
    step();
    rst_n = 1'b1;
    repeat (4) step();
    chk("s5_no_rsp", drsp_c.size() + frsp_c.size(), 0);
    clear_log();
    fq.push_back(9'd1);
    dq.push_back('{1'b0, 9'd2, 9'h000});
    run(40);
    chk("s5_tie_counts", {ffire.size(), dfire.size()}, {32'd1, 32'd1});
    if (ffire.size() == 1 && dfire.size() == 1) begin
      chk("s5_tie_data_first", dfire[0] < ffire[0], 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_W, default 9, memory word width.
REQ-002 Parameter ADDR_W, default 9, memory address width.
REQ-003 Parameter MEM_DEPTH, default 512, number of implemented words; legal addresses are 0..MEM_DEPTH-1.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 f_req_valid  input  1  fetch requester read request.
REQ-007 f_req_addr  input  ADDR_W  fetch address.
REQ-008 f_req_ready  output  1  fetch request accepted this cycle when high with f_req_valid.
REQ-009 f_rsp_valid  output  1  one-cycle fetch response strobe.
REQ-010 f_rsp_data  output  DATA_W  fetch read data.
REQ-011 f_rsp_err  output  1  fetch address out of range.
REQ-012 d_req_valid  input  1  data requester request.
REQ-013 d_req_we  input  1  1 = write, 0 = read.
REQ-014 d_req_addr  input  ADDR_W  data address.
REQ-015 d_req_wdata  input  DATA_W  write data.
REQ-016 d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err  output  1/1/DATA_W/1  as REQ-008..011 for the data requester; d_rsp_valid also acknowledges writes.
REQ-017 mem_ren_A, mem_wen_A  output  1  main_memory port A read/write strobes.
REQ-018 mem_addr_A  output  ADDR_W; mem_wdata_A  output  DATA_W; mem_rdata_A  input  DATA_W  main_memory port A buses.
REQ-019 busy  output  1  high in any state other than IDLE.

Function
REQ-020 The FSM SHALL have three states: IDLE, ACCESS, RESP; each transaction takes exactly 3 cycles, IDLE -> ACCESS -> RESP -> IDLE.
REQ-021 Ready SHALL be asserted only in IDLE and only to the granted requester; the other requester's ready SHALL be 0.
REQ-022 When only one requester is valid in IDLE, it SHALL be granted.
REQ-023 When both are valid in IDLE, the requester not granted last SHALL win (round-robin); after reset, the data requester wins the first tie.
REQ-024 On valid&ready, the address, we (0 for fetch), wdata, and grant identity SHALL be registered, and the state SHALL move to ACCESS.
REQ-025 In ACCESS with an in-range address, exactly one of mem_ren_A/mem_wen_A SHALL be high for that one cycle, with the registered mem_addr_A and mem_wdata_A.
REQ-026 An address >= MEM_DEPTH SHALL produce no memory strobe and a response with err=1 and data 0.
REQ-027 In RESP, the granted requester's rsp_valid SHALL be high for exactly one cycle, with rsp_data = mem_rdata_A for in-range reads and 0 for writes; the other requester's rsp_valid SHALL stay 0.
REQ-028 Requests SHALL NOT be accepted in ACCESS or RESP; a requester SHALL hold valid and its payload stable until ready.
REQ-029 Port B of main_memory SHALL NOT be driven by this block.

Reset
REQ-030 While rst_n=0: state IDLE, all strobes/valids/err/busy 0, all data and address outputs 0, last-grant = fetch.
REQ-031 A reset asserted in ACCESS or RESP SHALL abort the transaction with no response, and no response SHALL be emitted after rst_n deasserts.

Structure
REQ-032 The package mic1_mem_pkg SHALL hold the DATA_W, ADDR_W, and MEM_DEPTH defaults and the state enum (IDLE, ACCESS, RESP).
REQ-033 A two-way round-robin grant sub-module rr_arb2 SHALL compute the grant; everything else SHALL live in mem_arbiter.

Verification
REQ-034 Data write addr 5 wdata 0x0AA, then data read addr 5 -> mem_wen_A pulse at cycle 1 of the write; d_rsp_valid at cycle 2 of the read with d_rsp_rdata=0x0AA, err=0.
REQ-035 Fetch read addr 7 (memory preloaded 0x0CC) -> f_req_ready in cycle 0, mem_ren_A in cycle 1, f_rsp_valid with data 0x0CC in cycle 2; d_rsp_valid stays 0.
REQ-036 Both requesters held valid continuously after reset -> grants alternate data, fetch, data, fetch, one every 3 cycles; busy low only in IDLE cycles.
REQ-037 MEM_DEPTH=10, data read addr 12 -> no memory strobe; d_rsp_valid with err=1 and data 0.
REQ-038 rst_n pulsed low during ACCESS of a read -> outputs return to 0 immediately, no rsp_valid afterwards, and the next tie grants data.
